// File: rtl/conversor_binario_bcd_if.sv
// Handshake/data bundle between the processor datapath and the
// binary-to-BCD converter.
//   master: drives start/valor/com_sinal, observes the result
//   slave : the converter itself
// Signals:
//   start     request conversion of valor (accepted only while idle)
//   valor     WIDTH-bit binary value
//   com_sinal 1: valor is two's complement, 0: unsigned
//   bcd       DIGITS packed BCD digits, digit 0 in bits [3:0]
//   negativo  last completed result was negative
//   ocupado   conversion in progress
//   pronto    one-cycle pulse, bcd/negativo just updated
interface conversor_binario_bcd_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [WIDTH-1:0]      valor;
   logic                  com_sinal;
   logic [4*DIGITS-1:0]   bcd;
   logic                  negativo;
   logic                  ocupado;
   logic                  pronto;

   modport master (
      output start, valor, com_sinal,
      input  bcd, negativo, ocupado, pronto
   );

   modport slave (
      input  start, valor, com_sinal,
      output bcd, negativo, ocupado, pronto
   );
endinterface

// File: rtl/conversor_binario_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding the per-digit
// 7-segment decoders. A value is taken on a start pulse, converted in WIDTH
// shift cycles, and the registered digit bank is only updated when the
// conversion completes, so displays never show intermediate shift states.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous reset, active low
//   bus      conversor_binario_bcd_if.slave (start/valor/com_sinal in,
//            bcd/negativo/ocupado/pronto out)
//
// state   | meaning
// --------+------------------------------------------------------------
// OCIOSO  | idle, waiting for start; outputs hold last result
// DESLOCA | one add-3/shift step per cycle, WIDTH steps in total
// FIM     | load blanked digits and sign into output regs, pulse pronto
module conversor_binario_bcd #(
   parameter int WIDTH       = 16,
   parameter int DIGITS      = 5,
   parameter bit APAGA_ZEROS = 1'b1
) (
   input logic                   clock,
   input logic                   reset_n,
   conversor_binario_bcd_if.slave bus
);

   localparam int BW    = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH);
   // digit 0 shows "0", all higher digits blank (4'hF) when blanking is on
   localparam logic [BW-1:0] BCD_RST = APAGA_ZEROS ? ({BW{1'b1}} << 4) : '0;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      DESLOCA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   estado_t          estado;
   logic [CNT_W-1:0] cnt;
   logic [BW-1:0]    scratch;
   logic [WIDTH-1:0] mag;
   logic             sinal;
   logic [BW-1:0]    bcd_q;
   logic             neg_q;
   logic             pronto_q;

   logic [WIDTH-1:0] mag_in;
   logic [BW-1:0]    ajustado;
   logic [BW-1:0]    apagado;
   logic             lider;

   // the most negative two's complement value wraps to 2**(WIDTH-1),
   // which is exactly its magnitude when read as unsigned
   assign mag_in = (bus.com_sinal && bus.valor[WIDTH-1]) ? (~bus.valor + WIDTH'(1)) : bus.valor;

   always_comb begin
      ajustado = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            ajustado[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   // leading-zero blanking: walk down from the top digit until the first
   // non-zero one; digit 0 is never blanked
   always_comb begin
      apagado = scratch;
      lider   = 1'b1;
      if (APAGA_ZEROS) begin
         for (int i = DIGITS - 1; i > 0; i--) begin
            if (lider && (scratch[4*i +: 4] == 4'd0))
               apagado[4*i +: 4] = 4'hF;
            else
               lider = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado   <= OCIOSO;
         cnt      <= '0;
         scratch  <= '0;
         mag      <= '0;
         sinal    <= 1'b0;
         bcd_q    <= BCD_RST;
         neg_q    <= 1'b0;
         pronto_q <= 1'b0;
      end else begin
         pronto_q <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (bus.start) begin
                  mag     <= mag_in;
                  sinal   <= bus.com_sinal & bus.valor[WIDTH-1];
                  scratch <= '0;
                  cnt     <= CNT_W'(WIDTH - 1);
                  estado  <= DESLOCA;
               end
            end
            DESLOCA: begin
               {scratch, mag} <= {ajustado, mag} << 1;
               if (cnt == '0)
                  estado <= FIM;
               else
                  cnt <= cnt - CNT_W'(1);
            end
            FIM: begin
               bcd_q    <= apagado;
               // a zero result is never flagged negative
               neg_q    <= sinal && (scratch != '0);
               pronto_q <= 1'b1;
               estado   <= OCIOSO;
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

   assign bus.bcd      = bcd_q;
   assign bus.negativo = neg_q;
   assign bus.pronto   = pronto_q;
   assign bus.ocupado  = (estado != OCIOSO);

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Bench for conversor_binario_bcd (WIDTH=16, DIGITS=5, blanking on).
// A cycle-level reference model computes digits with decimal arithmetic and
// tracks only "busy for WIDTH+1 edges after acceptance"; one compare process
// checks all outputs every cycle, and directed vectors add literal checks.
module tb_conversor_binario_bcd;
   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;
   localparam logic [19:0] BCD_RST = 20'hFFFF0;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   always #5 clock = ~clock;

   conversor_binario_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   conversor_binario_bcd #(
      .WIDTH       (WIDTH),
      .DIGITS      (DIGITS),
      .APAGA_ZEROS (1'b1)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic logic [19:0] esperado_bcd(input logic [15:0] v, input logic s);
      int m, top;
      logic [19:0] r;
      m   = (s && v[15]) ? (65536 - int'(v)) : int'(v);
      r   = '0;
      top = 0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         if ((m % 10) != 0) top = i;
         m = m / 10;
      end
      for (int i = 1; i < DIGITS; i++)
         if (i > top) r[4*i +: 4] = 4'hF;
      return r;
   endfunction

   function automatic logic esperado_neg(input logic [15:0] v, input logic s);
      return s && v[15];
   endfunction

   task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nome, got, exp, $time);
      end
   endtask

   // reference model
   logic        m_busy;
   int          m_left;
   logic        m_pronto;
   logic [19:0] m_bcd, m_pend_bcd;
   logic        m_neg, m_pend_neg;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_busy   = 1'b0;
         m_left   = 0;
         m_pronto = 1'b0;
         m_bcd    = BCD_RST;
         m_neg    = 1'b0;
      end else begin
         m_pronto = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy   = 1'b0;
               m_bcd    = m_pend_bcd;
               m_neg    = m_pend_neg;
               m_pronto = 1'b1;
            end
         end else if (bus.start) begin
            m_busy     = 1'b1;
            m_left     = WIDTH + 1;
            m_pend_bcd = esperado_bcd(bus.valor, bus.com_sinal);
            m_pend_neg = esperado_neg(bus.valor, bus.com_sinal);
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         check("model_ocupado",  32'(bus.ocupado),  32'(m_busy));
         check("model_pronto",   32'(bus.pronto),   32'(m_pronto));
         check("model_bcd",      32'(bus.bcd),      32'(m_bcd));
         check("model_negativo", 32'(bus.negativo), 32'(m_neg));
      end
   end

   task automatic lanca(input logic [15:0] v, input logic s);
      bus.start     = 1'b1;
      bus.valor     = v;
      bus.com_sinal = s;
   endtask

   // called with start already raised; waits for pronto and checks the result
   task automatic aguarda(input string nome, input logic [19:0] eb, input logic en,
                          input int pulso_meio, input logic [15:0] v_meio,
                          input bit encadeia, input logic [15:0] nv, input logic ns);
      int n;
      bit visto;
      n     = 0;
      visto = 1'b0;
      while (n < 40 && !visto) begin
         @(negedge clock);
         n++;
         if (n == 1) begin
            bus.start     = 1'b0;
            bus.valor     = 16'($urandom);
            bus.com_sinal = 1'($urandom);
         end
         if (pulso_meio != 0 && n == pulso_meio) lanca(v_meio, 1'b0);
         if (pulso_meio != 0 && n == pulso_meio + 1) bus.start = 1'b0;
         if (bus.pronto) visto = 1'b1;
      end
      check({nome, "_latencia"}, 32'(n), 32'd18);
      check({nome, "_bcd"}, 32'(bus.bcd), 32'(eb));
      check({nome, "_neg"}, 32'(bus.negativo), 32'(en));
      if (encadeia) lanca(nv, ns);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int np;
      bus.start     = 1'b0;
      bus.valor     = '0;
      bus.com_sinal = 1'b0;

      check("pin_1234",  32'(esperado_bcd(16'd1234, 1'b0)), 32'h000F1234);
      check("pin_m1",    32'(esperado_bcd(16'hFFFF, 1'b1)), 32'h000FFFF1);
      check("pin_65535", 32'(esperado_bcd(16'hFFFF, 1'b0)), 32'h00065535);
      check("pin_min",   32'(esperado_bcd(16'h8000, 1'b1)), 32'h00032768);
      check("pin_zero",  32'(esperado_bcd(16'h0000, 1'b1)), 32'h000FFFF0);

      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_bcd",     32'(bus.bcd),      32'(BCD_RST));
      check("rst_neg",     32'(bus.negativo), 32'd0);
      check("rst_ocupado", 32'(bus.ocupado),  32'd0);
      check("rst_pronto",  32'(bus.pronto),   32'd0);

      lanca(16'd1234, 1'b0);
      aguarda("u1234", 20'hF1234, 1'b0, 0, '0, 1'b0, '0, 1'b0);
      @(negedge clock);
      check("pronto_pulso", 32'(bus.pronto), 32'd0);

      lanca(16'hFFFF, 1'b1);
      aguarda("s_m1", 20'hFFFF1, 1'b1, 0, '0, 1'b0, '0, 1'b0);
      @(negedge clock); lanca(16'hFFFF, 1'b0);
      aguarda("u65535", 20'h65535, 1'b0, 0, '0, 1'b0, '0, 1'b0);
      @(negedge clock); lanca(16'h8000, 1'b1);
      aguarda("s_min", 20'h32768, 1'b1, 0, '0, 1'b0, '0, 1'b0);
      @(negedge clock); lanca(16'h0000, 1'b1);
      aguarda("zero", 20'hFFFF0, 1'b0, 0, '0, 1'b0, '0, 1'b0);
      @(negedge clock); lanca(16'hFF85, 1'b1);
      aguarda("s_m123", 20'hFF123, 1'b1, 0, '0, 1'b0, '0, 1'b0);
      @(negedge clock); lanca(16'd10000, 1'b0);
      aguarda("u10000", 20'h10000, 1'b0, 0, '0, 1'b0, '0, 1'b0);

      // re-pulse mid-conversion is ignored; start in pronto cycle chains
      @(negedge clock); lanca(16'd1234, 1'b0);
      aguarda("ignora", 20'hF1234, 1'b0, 5, 16'd9, 1'b1, 16'd40, 1'b0);
      aguarda("b2b", 20'hFFF40, 1'b0, 0, '0, 1'b0, '0, 1'b0);

      // reset in the middle of a conversion
      @(negedge clock); lanca(16'd777, 1'b0);
      repeat (7) begin
         @(negedge clock);
         bus.start = 1'b0;
      end
      #2 reset_n = 1'b0;
      #1;
      check("abort_ocupado", 32'(bus.ocupado),  32'd0);
      check("abort_pronto",  32'(bus.pronto),   32'd0);
      check("abort_bcd",     32'(bus.bcd),      32'(BCD_RST));
      check("abort_neg",     32'(bus.negativo), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      np = 0;
      repeat (25) begin
         @(negedge clock);
         if (bus.pronto) np++;
      end
      check("abort_sem_pronto", 32'(np), 32'd0);

      lanca(16'd99, 1'b0);
      aguarda("pos_reset", 20'hFFF99, 1'b0, 0, '0, 1'b0, '0, 1'b0);
      repeat (3) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
